// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one magnitude bit per clock.
// Produces sign, packed BCD digits and an overflow flag for a seven-segment display driver.
module seq_bin_to_bcd #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_signed_mode,
    input  logic [WIDTH-1:0]      i_bin_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_valid,
    output logic                  o_neg,
    output logic                  o_overflow,
    output logic [4*DIGITS-1:0]   o_bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    r_mag;
    logic [4*DIGITS-1:0] r_digits;
    logic                r_neg;
    logic                r_ovf;

    logic                w_neg_in;
    logic [WIDTH-1:0]    w_mag_in;
    logic [4*DIGITS-1:0] w_adj;

    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Sign/magnitude of the incoming value and the per-digit +3 adjust of the running digits.
    always_comb begin
        w_neg_in = i_signed_mode & i_bin_in[WIDTH-1];
        if (w_neg_in) begin
            w_mag_in = ~i_bin_in + WIDTH'(1);
        end else begin
            w_mag_in = i_bin_in;
        end
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = add3(r_digits[4*i +: 4]);
        end
    end

    // Conversion FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_mag      <= '0;
            r_digits   <= '0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_valid    <= 1'b0;
            o_neg      <= 1'b0;
            o_overflow <= 1'b0;
            o_bcd_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_mag    <= w_mag_in;
                        r_neg    <= w_neg_in;
                        r_digits <= '0;
                        r_ovf    <= 1'b0;
                        r_count  <= '0;
                        o_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    o_done   <= 1'b0;
                    // The bit leaving the top digit means the value no longer fits in DIGITS.
                    r_digits <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
                    r_mag    <= {r_mag[WIDTH-2:0], 1'b0};
                    if (w_adj[4*DIGITS-1]) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_ovf <= r_ovf;
                    end
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    o_bcd_out  <= r_ovf ? '1 : r_digits;
                    o_neg      <= r_neg;
                    o_overflow <= r_ovf;
                    o_done     <= 1'b1;
                    o_valid    <= 1'b1;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
